// File: rtl/tlb_replacer.sv
// Sv32 page-table walker: turns a TLB miss into one TlbEntry-shaped refill result,
// issuing at most two PTE reads and applying the valid/permission/accessed fault rules.
module tlb_replacer #(
  parameter int PADDR_WIDTH     = 34,
  parameter int TLB_INDEX_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       missValid,
  input  logic [19:0]                missVpn,
  input  logic                       satpMode,
  input  logic [PADDR_WIDTH-13:0]    satpPpn,
  output logic                       memReadEnable,
  output logic [PADDR_WIDTH-1:0]     memAddr,
  input  logic                       memReadDone,
  input  logic [31:0]                memReadValue,
  output logic                       done,
  output logic [TLB_INDEX_WIDTH-1:0] entryIndex,
  output logic [19:0]                entryVpn,
  output logic                       entryValid,
  output logic                       entryFault,
  output logic [PADDR_WIDTH-13:0]    entryPageNumber,
  output logic [4:0]                 entryFlags
);
  localparam int PPN_W = PADDR_WIDTH - 12;

  typedef enum logic [1:0] {S_IDLE, S_LEVEL1, S_LEVEL0, S_DONE} state_t;

  state_t                   state_reg, state_next;
  logic [19:0]              vpn_reg, vpn_next;
  logic                     mem_en_reg, mem_en_next;
  logic [PADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
  logic                     done_reg, done_next;
  logic                     valid_reg, valid_next;
  logic                     fault_reg, fault_next;
  logic [PPN_W-1:0]         ppn_reg, ppn_next;
  logic [4:0]               flags_reg, flags_next;

  logic       pte_v, pte_r, pte_w, pte_x, pte_a;
  logic       pte_leaf, pte_bad, l1_fault, l0_fault, read_ack;
  logic [4:0] pte_flags;
  logic       unused_pte_bits;

  assign pte_v     = memReadValue[0];
  assign pte_r     = memReadValue[1];
  assign pte_w     = memReadValue[2];
  assign pte_x     = memReadValue[3];
  assign pte_a     = memReadValue[6];
  assign pte_flags = {memReadValue[7], memReadValue[4], memReadValue[3], memReadValue[2], memReadValue[1]};
  assign pte_leaf  = pte_r | pte_x;
  assign pte_bad   = ~pte_v | (~pte_r & pte_w);
  // A superpage leaf must be 4 MiB aligned, so its PPN0 field has to be zero.
  assign l1_fault  = pte_bad | (pte_leaf & ((memReadValue[19:10] != 10'd0) | ~pte_a));
  assign l0_fault  = pte_bad | ~pte_leaf | ~pte_a;
  assign read_ack  = mem_en_reg & memReadDone;
  assign unused_pte_bits = ^{memReadValue[9:8], memReadValue[5]};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg    <= S_IDLE;
      vpn_reg      <= '0;
      mem_en_reg   <= 1'b0;
      mem_addr_reg <= '0;
      done_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      fault_reg    <= 1'b0;
      ppn_reg      <= '0;
      flags_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      vpn_reg      <= vpn_next;
      mem_en_reg   <= mem_en_next;
      mem_addr_reg <= mem_addr_next;
      done_reg     <= done_next;
      valid_reg    <= valid_next;
      fault_reg    <= fault_next;
      ppn_reg      <= ppn_next;
      flags_reg    <= flags_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    vpn_next      = vpn_reg;
    mem_en_next   = mem_en_reg;
    mem_addr_next = mem_addr_reg;
    done_next     = 1'b0;
    valid_next    = valid_reg;
    fault_next    = fault_reg;
    ppn_next      = ppn_reg;
    flags_next    = flags_reg;

    case (state_reg)
      S_IDLE: begin
        if (missValid) begin
          vpn_next = missVpn;
          if (!satpMode) begin
            state_next = S_DONE;
            done_next  = 1'b1;
            valid_next = 1'b1;
            fault_next = 1'b0;
            ppn_next   = PPN_W'(missVpn);
            flags_next = 5'b11111;
          end else begin
            state_next    = S_LEVEL1;
            mem_en_next   = 1'b1;
            mem_addr_next = PADDR_WIDTH'({satpPpn, missVpn[19:10], 2'b00});
          end
        end
      end

      S_LEVEL1: begin
        if (read_ack) begin
          if (l1_fault || pte_leaf) begin
            state_next  = S_DONE;
            mem_en_next = 1'b0;
            done_next   = 1'b1;
            valid_next  = 1'b1;
            fault_next  = l1_fault;
            ppn_next    = l1_fault ? '0 : PPN_W'({memReadValue[31:20], vpn_reg[9:0]});
            flags_next  = l1_fault ? 5'b0 : pte_flags;
          end else begin
            // Pointer PTE: stay in the read and retarget at the next-level table.
            state_next    = S_LEVEL0;
            mem_addr_next = PADDR_WIDTH'({memReadValue[31:10], vpn_reg[9:0], 2'b00});
          end
        end
      end

      S_LEVEL0: begin
        if (read_ack) begin
          state_next  = S_DONE;
          mem_en_next = 1'b0;
          done_next   = 1'b1;
          valid_next  = 1'b1;
          fault_next  = l0_fault;
          ppn_next    = l0_fault ? '0 : PPN_W'(memReadValue[31:10]);
          flags_next  = l0_fault ? 5'b0 : pte_flags;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next  = S_IDLE;
        mem_en_next = 1'b0;
      end
    endcase
  end

  assign memReadEnable   = mem_en_reg;
  assign memAddr         = mem_addr_reg;
  assign done            = done_reg;
  assign entryIndex      = vpn_reg[TLB_INDEX_WIDTH-1:0];
  assign entryVpn        = vpn_reg;
  assign entryValid      = valid_reg;
  assign entryFault      = fault_reg;
  assign entryPageNumber = ppn_reg;
  assign entryFlags      = flags_reg;
endmodule

// File: tb/tb_tlb_replacer.sv
// Bench for tlb_replacer: a sparse PTE memory with configurable wait states and a
// level-loop reference walker that predicts result, read addresses and latency.
module tb_tlb_replacer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, missValid, satpMode, memReadEnable, memReadDone, done;
  logic        entryValid, entryFault;
  logic [19:0] missVpn, entryVpn;
  logic [21:0] satpPpn, entryPageNumber;
  logic [33:0] memAddr;
  logic [31:0] memReadValue;
  logic [2:0]  entryIndex;
  logic [4:0]  entryFlags;

  tlb_replacer #(.PADDR_WIDTH(34), .TLB_INDEX_WIDTH(3)) dut (
    .clk(clk), .rstN(rstN), .missValid(missValid), .missVpn(missVpn),
    .satpMode(satpMode), .satpPpn(satpPpn), .memReadEnable(memReadEnable),
    .memAddr(memAddr), .memReadDone(memReadDone), .memReadValue(memReadValue),
    .done(done), .entryIndex(entryIndex), .entryVpn(entryVpn),
    .entryValid(entryValid), .entryFault(entryFault),
    .entryPageNumber(entryPageNumber), .entryFlags(entryFlags)
  );

  int checks = 0;
  int passed = 0;

  logic [31:0] mem_model [logic [33:0]];
  logic [33:0] read_log [$];
  int          resp_delay = 0;
  bit          resp_en = 1'b1;
  int          wait_cnt = 0;
  int          addr_moves = 0;
  logic [33:0] cur_addr = '0;
  logic        completed;

  function automatic logic [31:0] mem_read(input logic [33:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h0;
  endfunction

  // Memory responder: answers each read after resp_delay wait cycles.
  always @(posedge clk) begin
    #1;
    if (resp_en) begin
      completed   = memReadDone;
      memReadDone = 1'b0;
      if (!rstN || !memReadEnable) begin
        wait_cnt = 0;
      end else begin
        if (completed) wait_cnt = 0;
        if (wait_cnt == 0) cur_addr = memAddr;
        else if (memAddr !== cur_addr) addr_moves++;
        if (wait_cnt >= resp_delay) begin
          memReadDone  = 1'b1;
          memReadValue = mem_read(memAddr);
          read_log.push_back(memAddr);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Reference walk straight from the translation rules, one loop pass per level.
  function automatic void ref_walk(input logic [19:0] vpn, input logic mode, input logic [21:0] satp,
                                   output logic fault, output logic [21:0] ppn, output logic [4:0] flags,
                                   output int nreads, output logic [33:0] a1, output logic [33:0] a2);
    longint unsigned vpn1, vpn0, table_ppn, addr;
    logic [31:0] pte;
    fault = 1'b0; ppn = '0; flags = '0; nreads = 0; a1 = '0; a2 = '0;
    vpn1 = longint'(vpn) / 1024;
    vpn0 = longint'(vpn) % 1024;
    if (!mode) begin
      ppn = 22'(vpn);
      flags = 5'b11111;
      return;
    end
    table_ppn = longint'(satp);
    for (int level = 1; level >= 0; level--) begin
      addr = table_ppn * 4096 + ((level == 1) ? vpn1 : vpn0) * 4;
      if (level == 1) a1 = 34'(addr); else a2 = 34'(addr);
      nreads++;
      pte = mem_read(34'(addr));
      if (!pte[0] || (!pte[1] && pte[2])) begin fault = 1'b1; return; end
      if (pte[1] || pte[3]) begin
        if (!pte[6] || (level == 1 && ((longint'(pte) / 1024) % 1024) != 0)) begin
          fault = 1'b1;
          return;
        end
        ppn = (level == 1) ? 22'((longint'(pte) / 1048576) * 1024 + vpn0) : 22'(longint'(pte) / 1024);
        flags = {pte[7], pte[4], pte[3], pte[2], pte[1]};
        return;
      end
      if (level == 0) begin fault = 1'b1; return; end
      table_ppn = longint'(pte) / 1024;
    end
  endfunction

  task automatic run_walk(input string name, input logic [19:0] vpn, input logic mode,
                          input logic [21:0] satp, input int delay, input bit immediate,
                          input bit drop_early);
    logic e_fault;
    logic [21:0] e_ppn;
    logic [4:0] e_flags;
    logic [33:0] e_a1, e_a2;
    int e_reads, e_lat, lat;
    bit seen;
    ref_walk(vpn, mode, satp, e_fault, e_ppn, e_flags, e_reads, e_a1, e_a2);
    e_lat = 1 + e_reads * (1 + delay) + (immediate ? 1 : 0);
    if (!immediate) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) $display("FAIL %s idle_done: got %b want 0", name, done); else passed++;
    end
    resp_delay = delay;
    read_log.delete();
    addr_moves = 0;
    missVpn = vpn; satpMode = mode; satpPpn = satp; missValid = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (drop_early) missValid = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    missValid = 1'b0;
    checks++;
    if (!seen) $display("FAIL %s timeout: got no done want done within 200 cycles", name); else passed++;
    checks++;
    if (lat != e_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, e_lat); else passed++;
    checks++;
    if (entryValid !== 1'b1) $display("FAIL %s valid: got %b want 1", name, entryValid); else passed++;
    checks++;
    if (entryFault !== e_fault) $display("FAIL %s fault: got %b want %b", name, entryFault, e_fault); else passed++;
    checks++;
    if (entryPageNumber !== e_ppn) $display("FAIL %s ppn: got %06h want %06h", name, entryPageNumber, e_ppn); else passed++;
    checks++;
    if (entryFlags !== e_flags) $display("FAIL %s flags: got %05b want %05b", name, entryFlags, e_flags); else passed++;
    checks++;
    if (entryVpn !== vpn || entryIndex !== vpn[2:0])
      $display("FAIL %s tag: got vpn=%05h idx=%0d want vpn=%05h idx=%0d", name, entryVpn, entryIndex, vpn, vpn[2:0]);
    else passed++;
    checks++;
    if (read_log.size() != e_reads) $display("FAIL %s reads: got %0d want %0d", name, read_log.size(), e_reads); else passed++;
    if (e_reads >= 1) begin
      checks++;
      if (read_log.size() < 1 || read_log[0] !== e_a1)
        $display("FAIL %s l1_addr: got %09h want %09h", name, (read_log.size() > 0) ? read_log[0] : 34'h0, e_a1);
      else passed++;
    end
    if (e_reads == 2) begin
      checks++;
      if (read_log.size() < 2 || read_log[1] !== e_a2)
        $display("FAIL %s l0_addr: got %09h want %09h", name, (read_log.size() > 1) ? read_log[1] : 34'h0, e_a2);
      else passed++;
    end
    checks++;
    if (addr_moves != 0) $display("FAIL %s addr_stable: got %0d moves want 0", name, addr_moves); else passed++;
    $display("txn %-16s vpn=%05h mode=%0d delay=%0d fault=%0d ppn=%06h flags=%05b lat=%0d",
             name, vpn, mode, delay, entryFault, entryPageNumber, entryFlags, lat);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({memReadEnable, memAddr, done, entryValid, entryFault, entryPageNumber, entryFlags, entryIndex, entryVpn} !== '0)
      $display("FAIL reset_outputs: got en=%b addr=%h done=%b v=%b f=%b ppn=%h fl=%b idx=%h vpn=%h want all 0",
               memReadEnable, memAddr, done, entryValid, entryFault, entryPageNumber, entryFlags, entryIndex, entryVpn);
    else passed++;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_bare();
    mem_model.delete();
    run_walk("bare", 20'h12345, 1'b0, 22'h3ABCD, 0, 1'b0, 1'b0);
  endtask

  task automatic test_two_level();
    mem_model.delete();
    mem_model[34'h100004] = 32'h00080001;
    mem_model[34'h200004] = 32'h123450CF;
    run_walk("two_level", 20'h00401, 1'b1, 22'h00100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_superpage();
    mem_model.delete();
    mem_model[34'h100A8C] = 32'h4000004B;
    run_walk("superpage", {10'h2A3, 10'h155}, 1'b1, 22'h00100, 0, 1'b0, 1'b0);
    mem_model[34'h100A8C] = 32'h4000044B;
    run_walk("superpage_misal", {10'h2A3, 10'h155}, 1'b1, 22'h00100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_faults();
    logic [31:0] l0_ptes [4] = '{32'h000000C5, 32'h0000000F, 32'h00000001, 32'h123450CE};
    mem_model.delete();
    mem_model[34'h100004] = 32'h0;
    run_walk("fault_l1_inv", 20'h00401, 1'b1, 22'h00100, 0, 1'b0, 1'b0);
    mem_model[34'h100004] = 32'h00080001;
    foreach (l0_ptes[i]) begin
      mem_model[34'h200004] = l0_ptes[i];
      run_walk("fault_l0", 20'h00401, 1'b1, 22'h00100, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_wait_states();
    mem_model.delete();
    mem_model[34'h100004] = 32'h00080001;
    mem_model[34'h200004] = 32'h123450CF;
    run_walk("wait_states", 20'h00401, 1'b1, 22'h00100, 5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_walk();
    int i;
    mem_model.delete();
    mem_model[34'h100004] = 32'h00080001;
    mem_model[34'h200004] = 32'h123450CF;
    @(posedge clk); #1;
    resp_delay = 8;
    read_log.delete();
    missVpn = 20'h00401; satpMode = 1'b1; satpPpn = 22'h00100; missValid = 1'b1;
    i = 0;
    while (read_log.size() < 1 && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    missValid = 1'b0;
    checks++;
    if (read_log.size() < 1) $display("FAIL rst_mid l1_timeout: got no read want one"); else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (memReadEnable !== 1'b1 || memAddr !== 34'h200004)
      $display("FAIL rst_mid l0_wait: got en=%b addr=%09h want en=1 addr=200004", memReadEnable, memAddr);
    else passed++;
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checks++;
    if (memReadEnable !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid async_drop: got en=%b done=%b want 0 0", memReadEnable, done);
    else passed++;
    @(negedge clk);
    rstN = 1'b1;
    resp_en = 1'b0;
    @(posedge clk); #1;
    memReadDone = 1'b1;
    memReadValue = 32'h123450CF;
    @(posedge clk); #1;
    memReadDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || memReadEnable !== 1'b0 || entryValid !== 1'b0)
        $display("FAIL rst_mid late_done: got done=%b en=%b valid=%b want 0 0 0", done, memReadEnable, entryValid);
      else passed++;
    end
    resp_en = 1'b1;
    run_walk("fresh_after_rst", 20'h00401, 1'b1, 22'h00100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    mem_model.delete();
    mem_model[34'h100004] = 32'h00080001;
    mem_model[34'h200004] = 32'h123450CF;
    run_walk("b2b_first", 20'h0ABCD, 1'b0, 22'h00100, 0, 1'b0, 1'b0);
    run_walk("b2b_second", 20'h00401, 1'b1, 22'h00100, 0, 1'b1, 1'b0);
    run_walk("drop_mid_walk", 20'h00401, 1'b1, 22'h00100, 2, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_pte(input int kind, input bit l1);
    logic [31:0] p;
    p = $urandom;
    case (kind)
      0: p[7:0] = 8'h01;
      1: begin p[0] = 1'b1; p[1] = 1'b1; p[6] = 1'b1; if (l1) p[19:10] = '0; end
      2: begin p[0] = 1'b1; p[3:1] = 3'b100; p[6] = 1'b1; if (l1) p[19:10] = '0; end
      default: ;
    endcase
    return p;
  endfunction

  task automatic test_random();
    logic [19:0] vpn;
    logic [21:0] satp;
    logic [31:0] p1;
    int k1;
    bit imm, drop;
    longint unsigned a1, a2;
    for (int n = 0; n < 40; n++) begin
      mem_model.delete();
      vpn  = 20'($urandom);
      satp = 22'($urandom);
      k1   = $urandom_range(0, 3);
      p1   = rand_pte(k1, 1'b1);
      a1   = longint'(satp) * 4096 + (longint'(vpn) / 1024) * 4;
      mem_model[34'(a1)] = p1;
      if (k1 == 0) begin
        a2 = (longint'(p1) / 1024) * 4096 + (longint'(vpn) % 1024) * 4;
        mem_model[34'(a2)] = rand_pte($urandom_range(0, 3), 1'b0);
      end
      imm  = (n > 0) && ($urandom_range(0, 3) == 0);
      drop = !imm && ($urandom_range(0, 3) == 0);
      run_walk("random", vpn, 1'($urandom_range(0, 5) != 0), satp, $urandom_range(0, 3), imm, drop);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN = 1'b0; missValid = 1'b0; missVpn = '0; satpMode = 1'b0; satpPpn = '0;
    memReadDone = 1'b0; memReadValue = '0;
    test_reset();
    test_bare();
    test_two_level();
    test_superpage();
    test_faults();
    test_wait_states();
    test_reset_mid_walk();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
